// File: rtl/mci_pkg.sv
// Shared MCI types: boot sequencer state encoding and the MCU reset-request FSM states.
package mci_pkg;

    typedef enum logic [3:0] {
        BOOT_IDLE             = 4'd0,
        BOOT_OTP_FC           = 4'd1,
        BOOT_LCC              = 4'd2,
        BOOT_BREAKPOINT       = 4'd3,
        BOOT_MCU              = 4'd4,
        BOOT_WAIT_CPTRA_GO    = 4'd5,
        BOOT_CPTRA            = 4'd6,
        BOOT_WAIT_MCU_RST_REQ = 4'd7,
        BOOT_HOLD_MCU_RST     = 4'd8,
        BOOT_RST_MCU          = 4'd9,
        BOOT_UNKNOWN          = 4'd10
    } mci_boot_fsm_state_e;

    typedef enum logic [1:0] {
        REQ_IDLE     = 2'd0,
        REQ_HALT     = 2'd1,
        REQ_ASSERT   = 2'd2,
        REQ_WAIT_REL = 2'd3
    } mci_rst_req_fsm_e;

    localparam int unsigned MCI_HALT_TIMEOUT_DEFAULT = 200;

    function automatic logic rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/caliptra_prim_flop_2sync.sv
// Two-flop synchronizer for bringing asynchronous levels into the clk domain.
module caliptra_prim_flop_2sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mci_mcu_rst_req_ctrl.sv
// MCU reset requester: collects SW/Caliptra requests, halts the MCU, then asks the
// boot sequencer for an MCU reset; also keeps sticky reset-reason bits.
module mci_mcu_rst_req_ctrl
    import mci_pkg::*;
#(
    parameter int unsigned HALT_TIMEOUT = MCI_HALT_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                mci_rst_b,
    input  logic                sw_rst_req,
    input  logic                cptra_rst_req,
    input  mci_boot_fsm_state_e boot_fsm,
    input  logic                fw_boot_upd_reset,
    input  logic                fw_hitless_upd_reset,
    input  logic                mcu_cpu_halt_ack,
    input  logic [1:0]          reason_clr,
    output logic                mcu_rst_req,
    output logic                mcu_cpu_halt_req,
    output logic                rst_req_busy,
    output logic                halt_timeout_err,
    output logic [1:0]          reset_reason,
    output mci_rst_req_fsm_e    rst_req_fsm
);

    localparam int TMO_W = $clog2(HALT_TIMEOUT + 1);

    mci_rst_req_fsm_e state;
    logic             pending;
    logic [TMO_W-1:0] count;
    logic             halt_ack_sync;
    logic             cptra_q;
    logic [1:0]       flag_q;
    logic [1:0]       flag_rise;
    logic             new_req;
    logic             start;
    logic             tmo_hit;

    caliptra_prim_flop_2sync #(.WIDTH(1)) u_halt_ack_sync (
        .clk   (clk),
        .rst_b (mci_rst_b),
        .d     (mcu_cpu_halt_ack),
        .q     (halt_ack_sync)
    );

    assign new_req   = sw_rst_req | rise(cptra_rst_req, cptra_q);
    assign start     = (state == REQ_IDLE) && pending && (boot_fsm == BOOT_WAIT_MCU_RST_REQ);
    assign tmo_hit   = (count == TMO_W'(HALT_TIMEOUT));
    assign flag_rise = {rise(fw_hitless_upd_reset, flag_q[1]), rise(fw_boot_upd_reset, flag_q[0])};

    assign rst_req_busy = (state != REQ_IDLE) | pending;
    assign rst_req_fsm  = state;

    // Requests arriving while a sequence runs collapse into one replay; a new set beats the clear.
    always_ff @(posedge clk or negedge mci_rst_b) begin
        if (!mci_rst_b) begin
            pending <= 1'b0;
            cptra_q <= 1'b0;
        end else begin
            cptra_q <= cptra_rst_req;
            if (new_req) begin
                pending <= 1'b1;
            end else if (start) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge mci_rst_b) begin
        if (!mci_rst_b) begin
            state            <= REQ_IDLE;
            count            <= '0;
            mcu_rst_req      <= 1'b0;
            mcu_cpu_halt_req <= 1'b0;
            halt_timeout_err <= 1'b0;
        end else begin
            halt_timeout_err <= 1'b0;
            case (state)
                REQ_IDLE: begin
                    if (start) begin
                        state            <= REQ_HALT;
                        count            <= '0;
                        mcu_cpu_halt_req <= 1'b1;
                    end
                end
                REQ_HALT: begin
                    if (!tmo_hit) begin
                        count <= count + TMO_W'(1);
                    end
                    // A synchronized ack takes priority over an expiring timeout.
                    if (halt_ack_sync) begin
                        state       <= REQ_ASSERT;
                        mcu_rst_req <= 1'b1;
                    end else if (tmo_hit) begin
                        state            <= REQ_ASSERT;
                        mcu_rst_req      <= 1'b1;
                        halt_timeout_err <= 1'b1;
                    end
                end
                REQ_ASSERT: begin
                    if (boot_fsm == BOOT_RST_MCU) begin
                        state            <= REQ_WAIT_REL;
                        mcu_rst_req      <= 1'b0;
                        mcu_cpu_halt_req <= 1'b0;
                    end
                end
                REQ_WAIT_REL: begin
                    if (boot_fsm == BOOT_MCU || boot_fsm == BOOT_WAIT_MCU_RST_REQ) begin
                        state <= REQ_IDLE;
                    end
                end
                default: begin
                    state            <= REQ_IDLE;
                    count            <= '0;
                    mcu_rst_req      <= 1'b0;
                    mcu_cpu_halt_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge mci_rst_b) begin
        if (!mci_rst_b) begin
            flag_q       <= 2'b00;
            reset_reason <= 2'b00;
        end else begin
            flag_q       <= {fw_hitless_upd_reset, fw_boot_upd_reset};
            reset_reason <= (reset_reason & ~reason_clr) | flag_rise;
        end
    end

endmodule

// File: tb/tb_mci_mcu_rst_req_ctrl.sv
// Bench for mci_mcu_rst_req_ctrl: directed scenarios, a sequence-level reference model
// compared every cycle, plus literal expectations at the key latencies.
module tb_mci_mcu_rst_req_ctrl;
    import mci_pkg::*;

    localparam int HALT_TIMEOUT = 200;

    logic                clk = 1'b0;
    logic                mci_rst_b = 1'b0;
    logic                sw_rst_req = 1'b0;
    logic                cptra_rst_req = 1'b0;
    mci_boot_fsm_state_e boot_fsm = BOOT_IDLE;
    logic                fw_boot_upd_reset = 1'b0;
    logic                fw_hitless_upd_reset = 1'b0;
    logic                mcu_cpu_halt_ack = 1'b0;
    logic [1:0]          reason_clr = 2'b00;
    logic                mcu_rst_req;
    logic                mcu_cpu_halt_req;
    logic                rst_req_busy;
    logic                halt_timeout_err;
    logic [1:0]          reset_reason;
    mci_rst_req_fsm_e    rst_req_fsm;

    int checks = 0;
    int errors = 0;

    mci_mcu_rst_req_ctrl #(.HALT_TIMEOUT(HALT_TIMEOUT)) dut (
        .clk                  (clk),
        .mci_rst_b            (mci_rst_b),
        .sw_rst_req           (sw_rst_req),
        .cptra_rst_req        (cptra_rst_req),
        .boot_fsm             (boot_fsm),
        .fw_boot_upd_reset    (fw_boot_upd_reset),
        .fw_hitless_upd_reset (fw_hitless_upd_reset),
        .mcu_cpu_halt_ack     (mcu_cpu_halt_ack),
        .reason_clr           (reason_clr),
        .mcu_rst_req          (mcu_rst_req),
        .mcu_cpu_halt_req     (mcu_cpu_halt_req),
        .rst_req_busy         (rst_req_busy),
        .halt_timeout_err     (halt_timeout_err),
        .reset_reason         (reset_reason),
        .rst_req_fsm          (rst_req_fsm)
    );

    always #5 clk = ~clk;

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request waits until the sequencer is ready, the MCU is halted
    // (ack seen two clocks late, or timeout), reset is requested until the sequencer
    // takes it, then the sequence ends once the sequencer moves on.
    bit       m_pending = 0;
    bit       m_busy = 0;
    bit       m_halt = 0;
    bit       m_rst = 0;
    bit       m_err = 0;
    bit       m_cptra_prev = 0;
    bit [1:0] m_reason = 0;
    bit [1:0] m_flag_prev = 0;
    bit [1:0] m_ack_hist = 0;
    int       m_wait = 0;

    always @(posedge clk or negedge mci_rst_b) begin
        if (!mci_rst_b) begin
            m_pending = 0; m_busy = 0; m_halt = 0; m_rst = 0; m_err = 0;
            m_cptra_prev = 0; m_reason = 0; m_flag_prev = 0; m_ack_hist = 0; m_wait = 0;
        end else begin
            bit ack_seen;
            bit new_req;
            bit begin_seq;
            bit [1:0] flags;
            ack_seen     = m_ack_hist[1];
            m_ack_hist   = {m_ack_hist[0], mcu_cpu_halt_ack};
            new_req      = sw_rst_req || (cptra_rst_req && !m_cptra_prev);
            m_cptra_prev = cptra_rst_req;
            begin_seq    = !m_busy && m_pending && (boot_fsm == BOOT_WAIT_MCU_RST_REQ);
            m_pending    = new_req || (m_pending && !begin_seq);
            m_err        = 0;
            if (begin_seq) begin
                m_busy = 1; m_halt = 1; m_wait = 0;
            end else if (m_busy && m_halt && !m_rst) begin
                if (ack_seen) m_rst = 1;
                else if (m_wait >= HALT_TIMEOUT) begin m_rst = 1; m_err = 1; end
                else m_wait++;
            end else if (m_rst) begin
                if (boot_fsm == BOOT_RST_MCU) begin m_rst = 0; m_halt = 0; end
            end else if (m_busy) begin
                if (boot_fsm == BOOT_MCU || boot_fsm == BOOT_WAIT_MCU_RST_REQ) m_busy = 0;
            end
            flags       = {fw_hitless_upd_reset, fw_boot_upd_reset};
            m_reason    = (m_reason & ~reason_clr) | (flags & ~m_flag_prev);
            m_flag_prev = flags;
        end
    end

    always @(negedge clk) begin
        mci_rst_req_fsm_e ef;
        ef = !m_busy ? REQ_IDLE : (m_rst ? REQ_ASSERT : (m_halt ? REQ_HALT : REQ_WAIT_REL));
        check_b("mdl_mcu_rst_req", mcu_rst_req, m_rst);
        check_b("mdl_halt_req", mcu_cpu_halt_req, m_halt);
        check_b("mdl_busy", rst_req_busy, m_busy || m_pending);
        check_b("mdl_timeout_err", halt_timeout_err, m_err);
        check_v("mdl_reset_reason", 32'(reset_reason), 32'(m_reason));
        check_v("mdl_fsm", 32'(rst_req_fsm), 32'(ef));
    end

    int   seq_count = 0;
    logic halt_prev = 1'b0;
    always @(negedge clk) begin
        if (mcu_cpu_halt_req === 1'b1 && halt_prev !== 1'b1) seq_count++;
        halt_prev = mcu_cpu_halt_req;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sw();
        sw_rst_req = 1'b1;
        cycles(1);
        sw_rst_req = 1'b0;
    endtask

    task automatic wait_rst(input string name);
        int n;
        n = 0;
        while (mcu_rst_req !== 1'b1 && n < 500) begin
            cycles(1);
            n++;
        end
        check_b(name, mcu_rst_req, 1'b1);
    endtask

    initial begin
        int n;
        int base;
        cycles(2);
        check_b("reset_rst_req", mcu_rst_req, 1'b0);
        check_b("reset_halt_req", mcu_cpu_halt_req, 1'b0);
        check_b("reset_busy", rst_req_busy, 1'b0);
        check_v("reset_reason", 32'(reset_reason), 32'd0);
        check_v("reset_fsm", 32'(rst_req_fsm), 32'(REQ_IDLE));
        mci_rst_b = 1'b1;
        boot_fsm = BOOT_LCC;
        cycles(3);

        // 1: SW pulse while waiting, ack after a few cycles
        boot_fsm = BOOT_WAIT_MCU_RST_REQ;
        cycles(1);
        pulse_sw();
        check_b("t1_halt_plus1", mcu_cpu_halt_req, 1'b0);
        check_b("t1_busy_pending", rst_req_busy, 1'b1);
        cycles(1);
        check_b("t1_halt_plus2", mcu_cpu_halt_req, 1'b1);
        cycles(4);
        mcu_cpu_halt_ack = 1'b1;
        cycles(2);
        check_b("t1_rst_ack_plus2", mcu_rst_req, 1'b0);
        cycles(1);
        check_b("t1_rst_ack_plus3", mcu_rst_req, 1'b1);
        cycles(3);
        check_b("t1_rst_held", mcu_rst_req, 1'b1);
        check_b("t1_halt_held", mcu_cpu_halt_req, 1'b1);
        boot_fsm = BOOT_RST_MCU;
        fw_boot_upd_reset = 1'b1;
        cycles(1);
        check_b("t1_rst_dropped", mcu_rst_req, 1'b0);
        check_b("t1_halt_dropped", mcu_cpu_halt_req, 1'b0);
        check_v("t1_reason", 32'(reset_reason), 32'd1);
        check_v("t1_fsm_wait_rel", 32'(rst_req_fsm), 32'(REQ_WAIT_REL));
        mcu_cpu_halt_ack = 1'b0;
        fw_boot_upd_reset = 1'b0;
        boot_fsm = BOOT_MCU;
        cycles(1);
        check_v("t1_fsm_idle", 32'(rst_req_fsm), 32'(REQ_IDLE));

        // 2: no ack -> timeout; err lands 201 cycles after halt_req rises
        boot_fsm = BOOT_WAIT_MCU_RST_REQ;
        cycles(1);
        pulse_sw();
        cycles(1);
        check_b("t2_halt_up", mcu_cpu_halt_req, 1'b1);
        n = 0;
        while (halt_timeout_err !== 1'b1 && n < 400) begin
            cycles(1);
            n++;
        end
        check_v("t2_timeout_cycle", 32'(n), 32'd201);
        check_b("t2_rst_with_err", mcu_rst_req, 1'b1);
        cycles(1);
        check_b("t2_err_single", halt_timeout_err, 1'b0);
        check_b("t2_rst_held", mcu_rst_req, 1'b1);
        boot_fsm = BOOT_RST_MCU;
        fw_hitless_upd_reset = 1'b1;
        cycles(1);
        check_v("t2_reason", 32'(reset_reason), 32'd3);
        fw_hitless_upd_reset = 1'b0;
        boot_fsm = BOOT_MCU;
        cycles(1);

        // 3: request during BOOT_LCC stays pending
        boot_fsm = BOOT_LCC;
        cycles(1);
        pulse_sw();
        cycles(5);
        check_b("t3_no_halt", mcu_cpu_halt_req, 1'b0);
        check_b("t3_busy", rst_req_busy, 1'b1);
        base = seq_count;
        boot_fsm = BOOT_WAIT_MCU_RST_REQ;
        mcu_cpu_halt_ack = 1'b1;
        wait_rst("t3_rst_up");
        boot_fsm = BOOT_RST_MCU;
        cycles(1);
        mcu_cpu_halt_ack = 1'b0;
        boot_fsm = BOOT_WAIT_MCU_RST_REQ;
        cycles(10);
        check_v("t3_one_sequence", 32'(seq_count - base), 32'd1);
        check_b("t3_idle_busy", rst_req_busy, 1'b0);

        // 4: simultaneous cptra rise + sw pulse, then a pulse during REQ_ASSERT
        base = seq_count;
        cptra_rst_req = 1'b1;
        pulse_sw();
        mcu_cpu_halt_ack = 1'b1;
        wait_rst("t4_first_rst");
        pulse_sw();
        check_b("t4_busy", rst_req_busy, 1'b1);
        boot_fsm = BOOT_RST_MCU;
        cycles(1);
        mcu_cpu_halt_ack = 1'b0;
        boot_fsm = BOOT_WAIT_MCU_RST_REQ;
        cycles(3);
        mcu_cpu_halt_ack = 1'b1;
        wait_rst("t4_second_rst");
        check_v("t4_two_sequences", 32'(seq_count - base), 32'd2);
        boot_fsm = BOOT_RST_MCU;
        cycles(1);
        mcu_cpu_halt_ack = 1'b0;
        cptra_rst_req = 1'b0;
        boot_fsm = BOOT_MCU;
        cycles(3);
        boot_fsm = BOOT_WAIT_MCU_RST_REQ;
        cycles(10);
        check_v("t4_no_third", 32'(seq_count - base), 32'd2);
        check_b("t4_idle_busy", rst_req_busy, 1'b0);

        // 5: reason set beats clear
        reason_clr = 2'b11;
        cycles(1);
        check_v("t5_cleared", 32'(reset_reason), 32'd0);
        fw_boot_upd_reset = 1'b1;
        reason_clr = 2'b01;
        cycles(1);
        check_v("t5_set_beats_clr", 32'(reset_reason), 32'd1);
        cycles(1);
        check_v("t5_clr_alone", 32'(reset_reason), 32'd0);
        fw_hitless_upd_reset = 1'b1;
        reason_clr = 2'b10;
        cycles(1);
        check_v("t5_hitless_set", 32'(reset_reason), 32'd2);
        cycles(1);
        check_v("t5_hitless_clr", 32'(reset_reason), 32'd0);
        reason_clr = 2'b00;
        fw_boot_upd_reset = 1'b0;
        fw_hitless_upd_reset = 1'b0;
        cycles(1);

        // 6: async reset in REQ_ASSERT with a request pending
        pulse_sw();
        mcu_cpu_halt_ack = 1'b1;
        wait_rst("t6_rst_up");
        pulse_sw();
        @(posedge clk);
        #3;
        mci_rst_b = 1'b0;
        #1;
        check_b("t6_async_rst_req", mcu_rst_req, 1'b0);
        check_b("t6_async_halt", mcu_cpu_halt_req, 1'b0);
        check_b("t6_async_busy", rst_req_busy, 1'b0);
        check_v("t6_async_fsm", 32'(rst_req_fsm), 32'(REQ_IDLE));
        mcu_cpu_halt_ack = 1'b0;
        cycles(2);
        mci_rst_b = 1'b1;
        cycles(1);
        check_b("t6_no_pending", rst_req_busy, 1'b0);
        cycles(5);
        check_b("t6_no_replay", mcu_cpu_halt_req, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
